// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types for the command master slice.
//   addr_t / data_t / strb_t : bus field types
//   resp_t                   : BRESP/RRESP encodings
//   cmd_t                    : one queued command {write, addr, wdata, wstrb}
//   cmd_state_t              : command-master FSM states
package axi_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    logic  write;
    addr_t addr;
    data_t wdata;
    strb_t wstrb;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
  } cmd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle (AW/W/B/AR/R channels).
//   aclk, areset_n : bus clock and synchronous active-low reset
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave modport  : drives AW/W/AR ready, B/R payload+valid
interface axi_lite_if (
  input logic aclk,
  input logic areset_n
);

  logic                  awvalid;
  logic                  awready;
  axi_lite_pkg::addr_t   awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  axi_lite_pkg::data_t   wdata;
  axi_lite_pkg::strb_t   wstrb;

  logic                  bvalid;
  logic                  bready;
  axi_lite_pkg::resp_t   bresp;

  logic                  arvalid;
  logic                  arready;
  axi_lite_pkg::addr_t   araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  axi_lite_pkg::data_t   rdata;
  axi_lite_pkg::resp_t   rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  aclk, areset_n,
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/axi_lite_cmd_fifo.sv
// axi_lite_cmd_fifo: synchronous FIFO of cmd_t.
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_push, i_push_data  : write side (ignored when full)
//   i_pop, o_pop_data    : read side, head is visible combinationally
//   o_full, o_empty      : flags derived from the registered pointers
module axi_lite_cmd_fifo
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  cmd_t i_push_data,
  input  logic i_pop,
  output cmd_t o_pop_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  cmd_t             r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Extra MSB distinguishes full (same index, different lap) from empty.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign o_pop_data = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: executes queued read/write commands on an AXI4-Lite
// master port, one transaction at a time, and returns one response each.
//   aclk, areset_n       : clock, synchronous active-low reset
//   m_axi_lite           : axi_lite_if master modport
//   cmd_valid/cmd_ready  : command stream {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb}
//   rsp_valid/rsp_ready  : response stream {rsp_write, rsp_rdata, rsp_resp}
//   busy                 : FSM active or commands pending
//   tx_count             : completed (accepted) responses, wrapping
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              areset_n,
  axi_lite_if.master        m_axi_lite,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  addr_t             cmd_addr,
  input  data_t             cmd_wdata,
  input  strb_t             cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output data_t             rsp_rdata,
  output resp_t             rsp_resp,
  output logic              busy,
  output logic [CNT_W-1:0]  tx_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmd_state_t        r_state;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  addr_t             r_awaddr;
  data_t             r_wdata;
  strb_t             r_wstrb;
  addr_t             r_araddr;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  data_t             r_rsp_rdata;
  resp_t             r_rsp_resp;
  logic [CNT_W-1:0]  r_tx_count;

  cmd_t              w_push_cmd;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_aw_done;
  logic              w_w_done;

  assign w_push_cmd = '{write: cmd_write, addr: cmd_addr,
                        wdata: cmd_wdata, wstrb: cmd_wstrb};
  assign w_pop      = (r_state == IDLE) && !w_empty;

  axi_lite_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .i_clk       (aclk),
    .i_rst_n     (areset_n),
    .i_push      (cmd_valid),
    .i_push_data (w_push_cmd),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A channel counts as done if it already handshook or handshakes now,
  // so AW and W may complete in either order or together.
  assign w_aw_done = !r_awvalid || m_axi_lite.awready;
  assign w_w_done  = !r_wvalid  || m_axi_lite.wready;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_araddr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= OKAY;
      r_tx_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            if (w_head.write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_head.addr;
              r_wdata   <= w_head.wdata;
              r_wstrb   <= w_head.wstrb;
              r_state   <= WR;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= w_head.addr;
              r_state   <= RD_A;
            end
          end
        end

        WR: begin
          if (r_awvalid && m_axi_lite.awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_lite.wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_B;
          end
        end

        WR_B: begin
          if (m_axi_lite.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= m_axi_lite.bresp;
            r_state     <= RSP;
          end
        end

        RD_A: begin
          if (m_axi_lite.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_R;
          end
        end

        RD_R: begin
          if (m_axi_lite.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= m_axi_lite.rdata;
            r_rsp_resp  <= m_axi_lite.rresp;
            r_state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_tx_count  <= r_tx_count + CNT_ONE;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axi_lite.awvalid = r_awvalid;
  assign m_axi_lite.awaddr  = r_awaddr;
  assign m_axi_lite.awprot  = '0;
  assign m_axi_lite.wvalid  = r_wvalid;
  assign m_axi_lite.wdata   = r_wdata;
  assign m_axi_lite.wstrb   = r_wstrb;
  assign m_axi_lite.bready  = r_bready;
  assign m_axi_lite.arvalid = r_arvalid;
  assign m_axi_lite.araddr  = r_araddr;
  assign m_axi_lite.arprot  = '0;
  assign m_axi_lite.rready  = r_rready;

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed, table-driven bench for axi_lite_cmd_master
// with a behavioural AXI4-Lite slave whose ready/response timing is steerable.
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_if ifc (.aclk(aclk), .areset_n(areset_n));

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  addr_t       cmd_addr  = '0;
  data_t       cmd_wdata = '0;
  strb_t       cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  data_t       rsp_rdata;
  resp_t       rsp_resp;
  logic        busy;
  logic [15:0] tx_count;

  axi_lite_cmd_master #(
    .CMD_DEPTH (4),
    .CNT_W     (16)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .m_axi_lite (ifc),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .busy       (busy),
    .tx_count   (tx_count)
  );

  // ---------------- behavioural slave ----------------
  logic  s_aw_en = 1'b1;
  logic  s_w_en  = 1'b1;
  logic  s_ar_en = 1'b1;
  logic  s_b_en  = 1'b1;
  logic  s_got_aw, s_got_w, s_bvalid, s_rvalid;
  addr_t s_awaddr;
  data_t s_wdata, s_rdata;
  strb_t s_wstrb;
  resp_t s_bresp, s_rresp;
  bit [31:0] buffer [256];
  int    aw_cnt = 0;
  int    w_cnt  = 0;
  int    ar_cnt = 0;
  addr_t aw_log [$];

  assign ifc.awready = s_aw_en;
  assign ifc.wready  = s_w_en;
  assign ifc.arready = s_ar_en;
  assign ifc.bvalid  = s_bvalid;
  assign ifc.bresp   = s_bresp;
  assign ifc.rvalid  = s_rvalid;
  assign ifc.rdata   = s_rdata;
  assign ifc.rresp   = s_rresp;

  always @(posedge aclk) begin
    if (!areset_n) begin
      s_got_aw <= 1'b0;
      s_got_w  <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_bresp  <= OKAY;
      s_rresp  <= OKAY;
      s_rdata  <= '0;
    end else begin
      if (s_bvalid && ifc.bready) s_bvalid <= 1'b0;
      if (s_rvalid && ifc.rready) s_rvalid <= 1'b0;
      if (ifc.awvalid && ifc.awready) begin
        s_got_aw <= 1'b1;
        s_awaddr <= ifc.awaddr;
        aw_cnt   <= aw_cnt + 1;
        aw_log.push_back(ifc.awaddr);
      end
      if (ifc.wvalid && ifc.wready) begin
        s_got_w <= 1'b1;
        s_wdata <= ifc.wdata;
        s_wstrb <= ifc.wstrb;
        w_cnt   <= w_cnt + 1;
      end
      if (s_got_aw && s_got_w && !s_bvalid && s_b_en) begin
        if (s_awaddr < 32'h100) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) buffer[s_awaddr[7:0]][8*i +: 8] <= s_wdata[8*i +: 8];
          s_bresp <= OKAY;
        end else begin
          s_bresp <= SLVERR;
        end
        s_bvalid <= 1'b1;
        s_got_aw <= 1'b0;
        s_got_w  <= 1'b0;
      end
      if (ifc.arvalid && ifc.arready) begin
        s_rvalid <= 1'b1;
        ar_cnt   <= ar_cnt + 1;
        if (ifc.araddr < 32'h100) begin
          s_rdata <= buffer[ifc.araddr[7:0]];
          s_rresp <= OKAY;
        end else begin
          s_rdata <= '0;
          s_rresp <= SLVERR;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic w, input addr_t a, input data_t d, input strb_t s);
    int g = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && g < 500) begin @(negedge aclk); g++; end
    chk("push_accepted", {31'd0, cmd_ready}, 32'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic w, output data_t d, output resp_t r);
    int g = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && g < 500) begin @(negedge aclk); g++; end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    w = rsp_write; d = rsp_rdata; r = rsp_resp;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
  endtask

  task automatic order_test(input bit w_first, input addr_t a, input data_t d);
    int    g = 0;
    int    aw0, w0;
    bit    stable;
    logic  rw;
    data_t rd;
    resp_t rr;
    aw0 = aw_cnt; w0 = w_cnt;
    s_aw_en = 1'b0; s_w_en = 1'b0;
    push(1'b1, a, d, 4'hF);
    while (!ifc.awvalid && g < 100) begin @(negedge aclk); g++; end
    chk("ord_valids_up", {30'd0, ifc.awvalid, ifc.wvalid}, 32'd3);
    if (w_first) s_w_en = 1'b1; else s_aw_en = 1'b1;
    @(negedge aclk);
    s_w_en = 1'b0; s_aw_en = 1'b0;
    chk("ord_first_drop", {31'd0, w_first ? ifc.wvalid : ifc.awvalid}, 32'd0);
    stable = 1'b1;
    repeat (2) begin
      if (!(w_first ? ifc.awvalid : ifc.wvalid) || ifc.bready ||
          ifc.awaddr !== a || ifc.wdata !== d) stable = 1'b0;
      @(negedge aclk);
    end
    if (!(w_first ? ifc.awvalid : ifc.wvalid) || ifc.bready) stable = 1'b0;
    chk("ord_wait_both", {31'd0, stable}, 32'd1);
    if (w_first) s_aw_en = 1'b1; else s_w_en = 1'b1;
    @(negedge aclk);
    s_aw_en = 1'b1; s_w_en = 1'b1;
    chk("ord_second_drop", {30'd0, ifc.awvalid, ifc.wvalid}, 32'd0);
    chk("ord_in_wr_b", {31'd0, ifc.bready}, 32'd1);
    get_rsp(rw, rd, rr);
    chk("ord_rsp_write", {31'd0, rw}, 32'd1);
    chk("ord_rsp_resp", {30'd0, rr}, {30'd0, OKAY});
    chk("ord_aw_count", aw_cnt - aw0, 32'd1);
    chk("ord_w_count", w_cnt - w0, 32'd1);
    chk("ord_mem", buffer[a[7:0]], d);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic  wr;
    addr_t addr;
    data_t wdata;
    strb_t strb;
    data_t exp_rdata;
    resp_t exp_resp;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    logic  rw;
    data_t rd;
    resp_t rr;
    logic [15:0] tx0;
    int    ar0, g;
    bit    held;

    vecs[0] = '{1'b1, 32'h004, 32'hdeadbeef, 4'hF, 32'h0,        OKAY};
    vecs[1] = '{1'b0, 32'h004, 32'h0,        4'h0, 32'hdeadbeef, OKAY};
    vecs[2] = '{1'b1, 32'h00C, 32'haabbccdd, 4'h5, 32'h0,        OKAY};
    vecs[3] = '{1'b0, 32'h00C, 32'h0,        4'h0, 32'h00bb00dd, OKAY};
    vecs[4] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        SLVERR};
    vecs[5] = '{1'b1, 32'h104, 32'h11111111, 4'hF, 32'h0,        SLVERR};
    vecs[6] = '{1'b1, 32'h00C, 32'h99887766, 4'h2, 32'h0,        OKAY};
    vecs[7] = '{1'b0, 32'h00C, 32'h0,        4'h0, 32'h00bb77dd, OKAY};

    // Reset state, sampled while reset is still held.
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {27'd0, ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_fields", {29'd0, rsp_write, rsp_resp} | rsp_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_count", {16'd0, tx_count}, 32'd0);
    areset_n = 1'b1;
    @(negedge aclk);

    // Table-driven single commands.
    for (int i = 0; i < NV; i++) begin
      push(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      get_rsp(rw, rd, rr);
      chk($sformatf("vec%0d_write", i), {31'd0, rw}, {31'd0, vecs[i].wr});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_resp", i), {30'd0, rr}, {30'd0, vecs[i].exp_resp});
    end
    chk("tbl_tx_count", {16'd0, tx_count}, 32'd8);
    chk("tbl_mem4", buffer[4], 32'hdeadbeef);
    chk("tbl_idle", {31'd0, busy}, 32'd0);

    // Response back-pressure: read 0x8 held unaccepted for 10 cycles.
    push(1'b1, 32'h008, 32'h12345678, 4'hF);
    get_rsp(rw, rd, rr);
    tx0 = tx_count;
    ar0 = ar_cnt;
    push(1'b0, 32'h008, '0, '0);
    push(1'b0, 32'h004, '0, '0);
    g = 0;
    while (!rsp_valid && g < 200) begin @(negedge aclk); g++; end
    held = 1'b1;
    repeat (10) begin
      if (!rsp_valid || rsp_rdata !== 32'h12345678) held = 1'b0;
      @(negedge aclk);
    end
    chk("hold_stable", {31'd0, held}, 32'd1);
    chk("hold_one_ar", ar_cnt - ar0, 32'd1);
    chk("hold_tx_same", {16'd0, tx_count}, {16'd0, tx0});
    get_rsp(rw, rd, rr);
    chk("hold_rdata", rd, 32'h12345678);
    chk("hold_tx_inc", {16'd0, tx_count}, {16'd0, tx0 + 16'd1});
    get_rsp(rw, rd, rr);
    chk("hold_next_rdata", rd, 32'hdeadbeef);

    // AW/W ordering, both directions.
    order_test(1'b1, 32'h030, 32'h55aa55aa);
    order_test(1'b0, 32'h034, 32'h66bb66bb);

    // FIFO fill with AW stalled.
    do_reset();
    aw_log.delete();
    s_aw_en = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 32'h020 + 32'(4*i), 32'ha0 + 32'(i), 4'hF);
    chk("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    s_aw_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(rw, rd, rr);
      chk($sformatf("fill%0d_resp", i), {29'd0, rw, rr}, {29'd0, 1'b1, OKAY});
    end
    chk("fill_tx_count", {16'd0, tx_count}, 32'd5);
    chk("fill_aw_total", aw_log.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < aw_log.size())
        chk($sformatf("fill%0d_order", i), aw_log[i], 32'h020 + 32'(4*i));
      chk($sformatf("fill%0d_mem", i), buffer[8'h20 + 8'(4*i)], 32'ha0 + 32'(i));
    end

    // Reset in WR_B with two commands queued.
    s_b_en = 1'b0;
    push(1'b1, 32'h040, 32'h1, 4'hF);
    push(1'b1, 32'h044, 32'h2, 4'hF);
    push(1'b1, 32'h048, 32'h3, 4'hF);
    g = 0;
    while (!ifc.bready && g < 100) begin @(negedge aclk); g++; end
    chk("mid_in_wr_b", {31'd0, ifc.bready}, 32'd1);
    tx0 = tx_count;
    chk("mid_tx_before", {16'd0, tx0}, 32'd5);
    areset_n = 1'b0;
    @(negedge aclk);
    chk("mid_valids", {26'd0, ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready, rsp_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_tx_count", {16'd0, tx_count}, 32'd0);
    areset_n = 1'b1;
    s_b_en = 1'b1;
    held = 1'b0;
    repeat (6) begin
      if (rsp_valid || busy) held = 1'b1;
      @(negedge aclk);
    end
    chk("mid_no_rsp", {31'd0, held}, 32'd0);
    push(1'b1, 32'h004, 32'h0badf00d, 4'hF);
    get_rsp(rw, rd, rr);
    chk("post_rsp", {29'd0, rw, rr}, {29'd0, 1'b1, OKAY});
    chk("post_rdata", rd, 32'd0);
    chk("post_mem", buffer[4], 32'h0badf00d);
    chk("post_tx_count", {16'd0, tx_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Command-driven AXI4-Lite master. It accepts read/write commands on a valid/ready stream and buffers them in a small FIFO. It executes them one at a time on an axi_lite_if master port and returns one response per command on a valid/ready response stream. It sits upstream of axi_lite_slave in place of the pulse-started master, so benches and firmware-model blocks can issue arbitrary address/data sequences.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
CNT_W, 16, width of completed-transaction counter

Ports:
aclk  input  1  clock; the same net as m_axi_lite.aclk
areset_n  input  1  synchronous active-low reset; the same net as m_axi_lite.areset_n
m_axi_lite  interface  -  axi_lite_if, master modport (AW/W/B/AR/R channels)
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO not full
cmd_write  input  1  1=write, 0=read
cmd_addr  input  addr_t  byte address
cmd_wdata  input  data_t  write data (ignored for reads)
cmd_wstrb  input  strb_t  write strobes (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_write  output  1  echo of command type
rsp_rdata  output  data_t  read data; 0 for writes
rsp_resp  output  resp_t  BRESP or RRESP
busy  output  1  FSM not IDLE or FIFO not empty
tx_count  output  CNT_W  completed transactions; wraps at 2^CNT_W

Behaviour:
- Reset (areset_n=0 sampled at a rising aclk edge): FIFO emptied; FSM to IDLE. All outputs are 0 except cmd_ready=1: awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_*, busy, tx_count. A reset mid-transaction abandons it with no response. The bench also resets the slave.
- Command FIFO: push when cmd_valid&&cmd_ready. cmd_ready = !full. Push and pop may occur in the same cycle when full: pop frees a slot, but cmd_ready is still derived from registered full, so the push is refused that cycle.
- FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE: if FIFO not empty, pop the head into the command register. Next state is WR (write) or RD_A (read). awvalid/wvalid or arvalid assert on the cycle after the pop. Minimum pop-to-valid latency is 1 cycle.
- WR: awvalid and wvalid are both asserted with awaddr/wdata/wstrb from the command register and awprot=0. Each valid drops independently in the cycle after its own handshake (awvalid&&awready, wvalid&&wready). Either order and same-cycle completion are legal. The state leaves for WR_B only after both handshakes have completed. The address and data must stay stable while their valid is high.
- WR_B: bready=1. On bvalid, capture bresp, set rsp_write=1 and rsp_rdata=0, then go to RSP.
- RD_A: arvalid=1 with araddr from the command register. On arready, drop arvalid and go to RD_R.
- RD_R: rready=1. On rvalid, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1 and the rsp_* fields are held stable. On rsp_ready, tx_count increments and the state returns to IDLE. A new pop may happen in the same cycle IDLE is entered, which is one cycle after rsp accept.
- There is at most one AXI transaction outstanding. No handshake waits are bounded; a hung slave holds the FSM in its state indefinitely.
- SLVERR/DECERR are passed through unchanged and still count in tx_count.
- busy = (state!=IDLE) || !empty.

Decomposition:
- axi_lite_pkg gains:
  - strb_t (logic [DATA_W/8-1:0])
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - cmd_t packed struct {write, addr, wdata, wstrb}
  - state enum cmd_state_t
- addr_t and data_t are reused from the package.
- Sub-module axi_lite_cmd_fifo: a synchronous FIFO of cmd_t, parameterised DEPTH, with full/empty flags, synchronous active-low reset, and registered pointers carrying one extra wrap bit.

Test Plan:
- Write {addr=0x4, data=0xdeadbeef, strb=0xF}, then read 0x4 -> slave.buffer[4]==0xdeadbeef; the write rsp has resp=OKAY and rdata=0; the read rsp has rdata=0xdeadbeef and resp=OKAY; tx_count==2.
- Push 5 commands back-to-back with the slave stalled (awready=0) and CMD_DEPTH=4 -> cmd_ready falls after the 4th push plus the one held in the FSM. All 5 complete in order once the slave is released, and tx_count==5.
- Slave accepts W three cycles before AW, then repeat with AW before W -> the FSM waits for both, each valid drops exactly 1 cycle after its own handshake, and the bus carries exactly one AW and one W per write.
- Hold rsp_ready=0 for 10 cycles after a read of 0x8 returning 0x12345678 -> rsp_valid stays 1 with rdata stable, no new AR is issued, and on accept tx_count increments by exactly 1.
- Slave returns RRESP=SLVERR for a read of 0x100 -> rsp_resp==2'b10 and tx_count still increments.
- Assert areset_n=0 while in WR_B with 2 commands queued -> the next cycle shows all valids 0, busy=0, tx_count=0, and no rsp emitted. A fresh write of 0x4 after release completes normally.
